// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO round-robin drain arbiter.
// Holds the arbiter state encoding, the statistics counter width and
// a cyclic-first search used by the round-robin picker.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W     = 32;
   localparam int MAX_PORTS  = 16;
   localparam int BEAT_CNT_W = 8;

   // Returns the first set index of req searching cyclically from last+1,
   // wrapping over n ports. Returns 0 when nothing is requested.
   function automatic int rr_next(input logic [MAX_PORTS-1:0] req,
                                  input int last,
                                  input int n);
      int   pick;
      int   idx;
      logic hit;
      pick = 0;
      idx  = 0;
      hit  = 1'b0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         idx = (last + k) % n;
         if (!hit && (k <= n) && req[idx]) begin
            pick = idx;
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: given a request vector and
// the previously granted index, returns the next requester in cyclic order.
// Reusable on the write side of other arbiters.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] last_i,
   output logic [PW-1:0] idx_o,
   output logic          found_o
);

   logic [MAX_PORTS-1:0] reqWide;

   // Widen the request vector to the helper's fixed width and search from last+1.
   always_comb begin
      reqWide        = '0;
      reqWide[N-1:0] = req_i;
      idx_o          = PW'(rr_next(reqWide, int'(last_i), N));
      found_o        = |req_i;
   end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain arbiter: empties a bank of FWFT sync FIFOs into one
// registered valid/ready stream, tagging each beat with its source port.
// Beat mode releases after MAX_BURST pops or when the granted queue empties;
// packet mode holds the grant until a beat with bit DWIDTH-1 set is popped.
// Optional per-port beat and stall counters: define FIFO_ARB_STATS_EN.
module fifo_rr_drain_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DWIDTH    = 32,
   parameter int MAX_BURST = 8,
   parameter int PKT_MODE  = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS*DWIDTH-1:0]    q_rd_data,
   input  logic [NUM_PORTS-1:0]           q_rd_empty,
   output logic [NUM_PORTS-1:0]           q_rd_en,
`ifdef FIFO_ARB_STATS_EN
   input  logic                           stat_clr,
   output logic [NUM_PORTS*STAT_W-1:0]    stat_beats,
   output logic [STAT_W-1:0]              stat_stall,
`endif
   output logic [DWIDTH-1:0]              m_data,
   output logic [$clog2(NUM_PORTS)-1:0]   m_port,
   output logic                           m_valid,
   input  logic                           m_ready
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST - 1);
   localparam logic [BEAT_CNT_W-1:0] CNT_MAX    = {BEAT_CNT_W{1'b1}};

   arb_state_t              state_q, state_d;
   logic [PW-1:0]           grant_q, grant_d;
   logic [PW-1:0]           lastGrant_q, lastGrant_d;
   logic [BEAT_CNT_W-1:0]   beatCnt_q, beatCnt_d;
   logic                    mValid_q, mValid_d;
   logic [DWIDTH-1:0]       mData_q, mData_d;
   logic [PW-1:0]           mPort_q, mPort_d;

   logic [PW-1:0]           pickIdx;
   logic                    pickFound;
   logic                    canLoad;
   logic                    pop;
   logic                    grantEmpty;
   logic [DWIDTH-1:0]       grantData;

   rr_pick #(
      .N  (NUM_PORTS),
      .PW (PW)
   ) uPick (
      .req_i   (~q_rd_empty),
      .last_i  (lastGrant_q),
      .idx_o   (pickIdx),
      .found_o (pickFound)
   );

   assign canLoad    = ~mValid_q | m_ready;
   assign grantEmpty = q_rd_empty[grant_q];
   assign grantData  = q_rd_data[grant_q*DWIDTH +: DWIDTH];

   // Grant selection, pop strobe and burst release decisions.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      beatCnt_d   = beatCnt_q;
      pop         = 1'b0;
      q_rd_en     = '0;
      case (state_q)
         IDLE: begin
            if (pickFound) begin
               grant_d     = pickIdx;
               lastGrant_d = pickIdx;
               beatCnt_d   = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            pop              = canLoad & ~grantEmpty;
            q_rd_en[grant_q] = pop;
            if (pop && (beatCnt_q != CNT_MAX)) begin
               beatCnt_d = beatCnt_q + 1'b1;
            end
            if (PKT_MODE != 0) begin
               if (pop && grantData[DWIDTH-1]) begin
                  state_d = IDLE;
               end
            end else if ((pop && (beatCnt_q == BURST_LAST)) || grantEmpty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register loads on a pop and drains when the consumer accepts.
   always_comb begin
      mValid_d = mValid_q;
      mData_d  = mData_q;
      mPort_d  = mPort_q;
      if (pop) begin
         mValid_d = 1'b1;
         mData_d  = grantData;
         mPort_d  = grant_q;
      end else if (m_ready) begin
         mValid_d = 1'b0;
      end
   end

   // State and output registers; reset drops any in-flight grant and beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= PW'(NUM_PORTS - 1);
         beatCnt_q   <= '0;
         mValid_q    <= 1'b0;
         mData_q     <= '0;
         mPort_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         beatCnt_q   <= beatCnt_d;
         mValid_q    <= mValid_d;
         mData_q     <= mData_d;
         mPort_q     <= mPort_d;
      end
   end

   assign m_valid = mValid_q;
   assign m_data  = mData_q;
   assign m_port  = mPort_q;

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] statBeats_q [NUM_PORTS];
   logic [STAT_W-1:0] statStall_q;

   // Per-port popped-beat counters and BURST stall counter; clear wins over count.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            statBeats_q[i] <= '0;
         end
         statStall_q <= '0;
      end else begin
         if (pop) begin
            statBeats_q[grant_q] <= statBeats_q[grant_q] + 1'b1;
         end
         if ((state_q == BURST) && !pop) begin
            statStall_q <= statStall_q + 1'b1;
         end
      end
   end

   // Flatten the counter array onto the output bus.
   always_comb begin
      stat_beats = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         stat_beats[i*STAT_W +: STAT_W] = statBeats_q[i];
      end
   end

   assign stat_stall = statStall_q;
`endif

endmodule
